evm_ballot_unit: RTL and testbench
==================================

// Module: evm_ballot_unit
// PURPOSE
//  Parametrised electronic voting machine core: NUM_CAND candidates, per-candidate saturating counters.
//  Votes count only after a presiding-officer arm, with a hold-qualified, one-hot button press.
//  Result mode reads back any candidate's tally. Sits between the panel button inputs and the display/driver logic.
// PARAMETERS
//  NUM_CAND  4   number of candidates / buttons (>=2)
//  CNT_W     8   width of each vote counter and of result
//  HOLD_CYC  10  consecutive synchronised samples a press must stay stable to qualify (>=1)
//  SEL_W     $clog2(NUM_CAND)  localparam, candidate index width
// PORTS
//  clock             in   1         system clock, rising edge
//  reset             in   1         asynchronous, active-high; clears all state
//  mode              in   1         0 = vote, 1 = result readback
//  ballot_arm        in   1         officer pulse; arms exactly one vote
//  candidate_button  in   NUM_CAND  raw asynchronous buttons, bit i = candidate i
//  armed             out  1         high while a ballot is armed and not yet cast
//  vote_ack          out  1         one-cycle pulse when a vote is committed
//  vote_idx          out  SEL_W     index of committed vote, valid with vote_ack
//  result            out  CNT_W     selected tally in mode 1, 0 in mode 0
//  overflow          out  1         sticky: a vote arrived at a saturated counter
// BEHAVIOUR
//  Reset: all counters 0, state IDLE; armed, vote_ack, vote_idx, result, overflow all 0.
//  candidate_button passes through a 2-flop synchroniser; all latencies below count from the synchronised value (btn_s).
//  FSM, mode 0:
//   IDLE:    ballot_arm=1 -> ARMED (armed=1 next cycle). Buttons ignored.
//   ARMED:   btn_s one-hot -> HOLD; latch idx; hold_cnt=1. Zero- or multi-hot -> stay.
//   HOLD:    btn_s == latched one-hot -> hold_cnt++; after HOLD_CYC-th matching sample -> COMMIT.
//            Any change (release, second button) -> ARMED; hold_cnt cleared; no vote.
//   COMMIT:  single cycle. vote_ack=1, vote_idx=idx, count[idx]++ (saturating), armed=0 -> RELEASE.
//   RELEASE: wait until btn_s==0, then -> IDLE. A held button never casts a second vote.
//  ballot_arm outside IDLE: ignored (no queuing).
//  Saturation: count at 2^CNT_W-1 holds its value; overflow set sticky, cleared only by reset. vote_ack still pulses.
//  mode 1: FSM forced to IDLE, pending arm/hold aborted, no counts change.
//   If btn_s is one-hot, result <= count[idx] registered (1 clock after btn_s).
//   Otherwise result holds its last value. Entering mode 0 clears result to 0 next cycle.
//  Simultaneous: COMMIT with mode rising -> vote completes, then IDLE. Reset asserted mid-HOLD or mid-COMMIT -> no partial count.
// CONFIGURATION
//  EVM_WINNER_EN defined: extra ports winner out SEL_W, tie out 1, registered one cycle after any count change.
//   winner = lowest index holding the maximum count.
//   tie = 1 when >=2 candidates share the maximum (after reset: winner=0, tie=1).
//  EVM_WINNER_EN undefined: ports and comparator logic absent; all other behaviour identical.
// STRUCTURE
//  Package evm_pkg holds:
//   evm_state_e {IDLE, ARMED, HOLD, COMMIT, RELEASE}
//   evm_mode_e {MODE_VOTE=0, MODE_RESULT=1}
//   function onehot_idx (returns index, valid flag)
//  Sub-module evm_button_qualifier: synchroniser + one-hot detect + hold counter.
//   Outputs qual_pulse and qual_idx. FSM, counters and readback stay in the top.
// TESTING (NUM_CAND=4, CNT_W=8, HOLD_CYC=10 unless stated)
//  1 Reset pulse mid-run -> all counts 0; armed, vote_ack, result, overflow = 0 immediately (asynchronous).
//  2 Arm; hold button0 for 150 ns (15 clk) -> one vote_ack, vote_idx=0, count0=1. Release, re-press without arm -> no vote.
//  3 Arm; button0 for 5 clk, release, then button1 for 12 clk -> only count1=1, count0 unchanged.
//  4 Arm; buttons 0 and 2 pressed together for 20 clk -> no vote, armed stays 1.
//  5 Counts {3,1,0,0}; mode=1, press button0 -> result=3; press button2 -> result=0;
//    press none -> result holds; with EVM_WINNER_EN, winner=0, tie=0.
//  6 CNT_W=2: four armed votes for button3 -> count3=3, overflow=1, four vote_ack pulses.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared types and helpers for the evm_ballot_unit voting core.
// The optional winner/tie comparator is enabled by defining EVM_WINNER_EN.
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HOLD,
    COMMIT,
    RELEASE
  } evm_state_e;

  typedef enum logic {
    MODE_VOTE   = 1'b0,
    MODE_RESULT = 1'b1
  } evm_mode_e;

  localparam int EVM_MAX_CAND = 32;
  localparam int EVM_IDX_W    = 5;

  typedef struct packed {
    logic [EVM_IDX_W-1:0] idx;
    logic                 valid;
  } onehot_t;

  // valid only when exactly one bit is set; idx is then that bit's position
  function automatic onehot_t onehot_idx(input logic [EVM_MAX_CAND-1:0] vec);
    onehot_t     res;
    int unsigned ones;
    res.idx   = '0;
    res.valid = 1'b0;
    ones      = 0;
    for (int i = 0; i < EVM_MAX_CAND; i++) begin
      if (vec[i]) begin
        ones    = ones + 1;
        res.idx = EVM_IDX_W'(i);
      end
    end
    res.valid = (ones == 1);
    return res;
  endfunction

endpackage

// File: rtl/evm_button_qualifier.sv
// Button synchroniser, one-hot decode and hold counter for evm_ballot_unit.
// Emits qual_pulse once a single button has been held for HOLD_CYC samples.
module evm_button_qualifier
  import evm_pkg::*;
#(
  parameter  int NUM_CAND = 4,
  parameter  int HOLD_CYC = 10,
  localparam int SEL_W    = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                holding,
  input  logic [NUM_CAND-1:0] button,
  output logic [NUM_CAND-1:0] btn_s,
  output logic                btn_onehot,
  output logic [SEL_W-1:0]    btn_idx,
  output logic                hold_match,
  output logic                qual_pulse,
  output logic [SEL_W-1:0]    qual_idx
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  logic [NUM_CAND-1:0] sync1_reg, sync2_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [SEL_W-1:0]    idx_reg, idx_next;
  onehot_t             oh;
  logic                idx_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= button;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_s      = sync2_reg;
  assign oh         = onehot_idx(EVM_MAX_CAND'(sync2_reg));
  assign btn_onehot = oh.valid;
  assign btn_idx    = oh.idx[SEL_W-1:0];
  assign idx_unused = ^(oh.idx >> SEL_W);
  assign hold_match = (sync2_reg == (NUM_CAND'(1) << idx_reg));

  // the first one-hot sample while armed already counts as sample 1
  always_comb begin
    hold_cnt_next = '0;
    idx_next      = idx_reg;
    if (en) begin
      if (!holding) begin
        if (oh.valid) begin
          hold_cnt_next = HOLD_W'(1);
          idx_next      = oh.idx[SEL_W-1:0];
        end
      end else if (hold_match && (hold_cnt_reg < HOLD_W'(HOLD_CYC))) begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
      end
    end
  end

  assign qual_pulse = en && (hold_cnt_next == HOLD_W'(HOLD_CYC));
  assign qual_idx   = idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg <= '0;
      idx_reg      <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      idx_reg      <= idx_next;
    end
  end

endmodule

// File: rtl/evm_ballot_unit.sv
// Electronic voting machine core: arm/hold/commit FSM, saturating tallies, readback.
// Define EVM_WINNER_EN to add the registered winner/tie outputs.
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter  int NUM_CAND = 4,
  parameter  int CNT_W    = 8,
  parameter  int HOLD_CYC = 10,
  localparam int SEL_W    = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] candidate_button,
  output logic                armed,
  output logic                vote_ack,
  output logic [SEL_W-1:0]    vote_idx,
  output logic [CNT_W-1:0]    result,
  output logic                overflow
`ifdef EVM_WINNER_EN
  ,
  output logic [SEL_W-1:0]    winner,
  output logic                tie
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  evm_state_e          state_reg, state_next;
  evm_mode_e           mode_e;
  logic [NUM_CAND-1:0] btn_s;
  logic                btn_onehot, hold_match, qual_pulse, q_en, q_holding;
  logic [SEL_W-1:0]    btn_idx, qual_idx;
  logic [CNT_W-1:0]    count_vec [NUM_CAND];
  logic [CNT_W-1:0]    result_reg;
  logic                overflow_reg;

  assign mode_e    = evm_mode_e'(mode);
  assign q_holding = (state_reg == HOLD);
  assign q_en      = ((state_reg == ARMED) || (state_reg == HOLD)) && (mode_e == MODE_VOTE);

  evm_button_qualifier #(
    .NUM_CAND (NUM_CAND),
    .HOLD_CYC (HOLD_CYC)
  ) u_qual (
    .clk        (clock),
    .rst        (reset),
    .en         (q_en),
    .holding    (q_holding),
    .button     (candidate_button),
    .btn_s      (btn_s),
    .btn_onehot (btn_onehot),
    .btn_idx    (btn_idx),
    .hold_match (hold_match),
    .qual_pulse (qual_pulse),
    .qual_idx   (qual_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ballot_arm) state_next = ARMED;
      ARMED: begin
        if (qual_pulse)      state_next = COMMIT;
        else if (btn_onehot) state_next = HOLD;
      end
      HOLD: begin
        if (qual_pulse)       state_next = COMMIT;
        else if (!hold_match) state_next = ARMED;
      end
      COMMIT:  state_next = RELEASE;
      RELEASE: if (btn_s == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // result mode aborts any ballot; a vote already in COMMIT still lands this cycle
    if (mode_e == MODE_RESULT) state_next = IDLE;
  end

  always_comb begin
    armed    = (state_reg == ARMED) || (state_reg == HOLD);
    vote_ack = (state_reg == COMMIT);
    vote_idx = vote_ack ? qual_idx : '0;
  end

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (vote_ack && (qual_idx == SEL_W'(gi)) && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
    assign count_vec[gi] = cnt_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      if (vote_ack && (count_vec[qual_idx] == CNT_MAX)) overflow_reg <= 1'b1;
      if (mode_e == MODE_VOTE)  result_reg <= '0;
      else if (btn_onehot)      result_reg <= count_vec[btn_idx];
    end
  end

  assign result   = result_reg;
  assign overflow = overflow_reg;

`ifdef EVM_WINNER_EN
  logic [SEL_W-1:0] winner_reg, winner_next;
  logic             tie_reg, tie_next;
  int               n_max;

  // lowest index wins on equal counts because only a strictly larger count replaces it
  always_comb begin
    winner_next = '0;
    n_max       = 0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (count_vec[i] > count_vec[winner_next]) winner_next = SEL_W'(i);
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (count_vec[i] == count_vec[winner_next]) n_max = n_max + 1;
    end
    tie_next = (n_max >= 2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      winner_reg <= '0;
      tie_reg    <= 1'b1;
    end else begin
      winner_reg <= winner_next;
      tie_reg    <= tie_next;
    end
  end

  assign winner = winner_reg;
  assign tie    = tie_reg;
`endif

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Randomised bench for evm_ballot_unit: two instances (8-bit and 2-bit tallies) share
// stimulus and are compared every cycle against a behavioural ballot model.
module tb_evm_ballot_unit;

  localparam int NC   = 4;
  localparam int HOLD = 10;
  localparam int MAX8 = 255;
  localparam int MAX2 = 3;

  logic          clock = 1'b0;
  logic          reset, mode, ballot_arm;
  logic [NC-1:0] candidate_button;

  logic       armed8, vote_ack8, overflow8, armed2, vote_ack2, overflow2;
  logic [1:0] vote_idx8, vote_idx2;
  logic [7:0] result8;
  logic [1:0] result2;
`ifdef EVM_WINNER_EN
  logic [1:0] winner8, winner2;
  logic       tie8, tie2;
`endif

  always #5 clock = ~clock;

  evm_ballot_unit #(.NUM_CAND(NC), .CNT_W(8), .HOLD_CYC(HOLD)) u_dut8 (
    .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
    .candidate_button(candidate_button), .armed(armed8), .vote_ack(vote_ack8),
    .vote_idx(vote_idx8), .result(result8), .overflow(overflow8)
`ifdef EVM_WINNER_EN
    , .winner(winner8), .tie(tie8)
`endif
  );

  evm_ballot_unit #(.NUM_CAND(NC), .CNT_W(2), .HOLD_CYC(HOLD)) u_dut2 (
    .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
    .candidate_button(candidate_button), .armed(armed2), .vote_ack(vote_ack2),
    .vote_idx(vote_idx2), .result(result2), .overflow(overflow2)
`ifdef EVM_WINNER_EN
    , .winner(winner2), .tie(tie2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int acks8 = 0;
  int acks2 = 0;
  int last_idx8 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // model: raw (unsaturated) tallies plus ballot progress
  bit [NC-1:0] m_s1, m_s2;
  bit          m_open, m_commit, m_await, m_ovf8, m_ovf2;
  int          m_idx, m_run, m_res;
  int          m_cnt [NC];
`ifdef EVM_WINNER_EN
  int          m_win8, m_win2;
  bit          m_tie8 = 1'b1, m_tie2 = 1'b1;
`endif

  always @(posedge clock or posedge reset) begin : model_step
    int bs_idx, run_n, idx_n;
    bit bs_one, open_n, commit_n, await_n;
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0;
      m_open <= 1'b0; m_commit <= 1'b0; m_await <= 1'b0;
      m_ovf8 <= 1'b0; m_ovf2 <= 1'b0;
      m_idx <= 0; m_run <= 0; m_res <= 0;
      for (int i = 0; i < NC; i++) m_cnt[i] <= 0;
`ifdef EVM_WINNER_EN
      m_win8 <= 0; m_win2 <= 0; m_tie8 <= 1'b1; m_tie2 <= 1'b1;
`endif
    end else begin
      bs_one = ($countones(m_s2) == 1);
      bs_idx = 0;
      for (int i = 0; i < NC; i++) if (m_s2[i]) bs_idx = i;
      m_s1 <= candidate_button;
      m_s2 <= m_s1;
      if (m_commit) begin
        m_cnt[m_idx] <= m_cnt[m_idx] + 1;
        if (m_cnt[m_idx] >= MAX8) m_ovf8 <= 1'b1;
        if (m_cnt[m_idx] >= MAX2) m_ovf2 <= 1'b1;
      end
      if (mode) begin
        if (bs_one) m_res <= m_cnt[bs_idx];
      end else begin
        m_res <= 0;
      end
      open_n = m_open; commit_n = 1'b0; await_n = m_await; run_n = m_run; idx_n = m_idx;
      if (m_commit) begin
        await_n = !mode; open_n = 1'b0; run_n = 0;
      end else if (mode) begin
        open_n = 1'b0; await_n = 1'b0; run_n = 0;
      end else if (m_await) begin
        if (m_s2 == '0) await_n = 1'b0;
      end else if (!m_open) begin
        if (ballot_arm) begin open_n = 1'b1; run_n = 0; end
      end else begin
        if (m_run == 0) begin
          if (bs_one) begin idx_n = bs_idx; run_n = 1; end
        end else if (m_s2 == (4'b0001 << m_idx)) begin
          run_n = m_run + 1;
        end else begin
          run_n = 0;
        end
        if (run_n == HOLD) begin commit_n = 1'b1; open_n = 1'b0; run_n = 0; end
      end
      m_open <= open_n; m_commit <= commit_n; m_await <= await_n;
      m_run <= run_n; m_idx <= idx_n;
`ifdef EVM_WINNER_EN
      begin
        int b8, b2, n8, n2;
        b8 = 0; b2 = 0; n8 = 0; n2 = 0;
        for (int i = 1; i < NC; i++) begin
          if (sat(m_cnt[i], MAX8) > sat(m_cnt[b8], MAX8)) b8 = i;
          if (sat(m_cnt[i], MAX2) > sat(m_cnt[b2], MAX2)) b2 = i;
        end
        for (int i = 0; i < NC; i++) begin
          if (sat(m_cnt[i], MAX8) == sat(m_cnt[b8], MAX8)) n8++;
          if (sat(m_cnt[i], MAX2) == sat(m_cnt[b2], MAX2)) n2++;
        end
        m_win8 <= b8; m_win2 <= b2; m_tie8 <= (n8 >= 2); m_tie2 <= (n2 >= 2);
      end
`endif
    end
  end

  always @(negedge clock) begin
    chk("armed8",    int'(armed8),    int'(m_open));
    chk("armed2",    int'(armed2),    int'(m_open));
    chk("vote_ack8", int'(vote_ack8), int'(m_commit));
    chk("vote_ack2", int'(vote_ack2), int'(m_commit));
    chk("vote_idx8", int'(vote_idx8), m_commit ? m_idx : 0);
    chk("vote_idx2", int'(vote_idx2), m_commit ? m_idx : 0);
    chk("result8",   int'(result8),   sat(m_res, MAX8));
    chk("result2",   int'(result2),   sat(m_res, MAX2));
    chk("overflow8", int'(overflow8), int'(m_ovf8));
    chk("overflow2", int'(overflow2), int'(m_ovf2));
`ifdef EVM_WINNER_EN
    chk("winner8", int'(winner8), m_win8);
    chk("winner2", int'(winner2), m_win2);
    chk("tie8",    int'(tie8),    int'(m_tie8));
    chk("tie2",    int'(tie2),    int'(m_tie2));
`endif
    if (vote_ack8) begin
      acks8     <= acks8 + 1;
      last_idx8 <= int'(vote_idx8);
    end
    if (vote_ack2) acks2 <= acks2 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [NC-1:0] mask, input int cycles);
    candidate_button = mask;
    tick(cycles);
  endtask

  task automatic arm_pulse();
    ballot_arm = 1'b1;
    tick(1);
    ballot_arm = 1'b0;
  endtask

  task automatic cast_vote(input int idx);
    logic [NC-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    arm_pulse();
    press(m, 14);
    press('0, 4);
  endtask

  // reset lands mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_armed",     int'(armed8),    0);
    chk("rst_vote_ack",  int'(vote_ack8), 0);
    chk("rst_result",    int'(result8),   0);
    chk("rst_overflow8", int'(overflow8), 0);
    chk("rst_overflow2", int'(overflow2), 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, a2, r;
    logic [NC-1:0] msk;
    reset = 1'b0; mode = 1'b0; ballot_arm = 1'b0; candidate_button = '0;
    #1 reset = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    tick(1);
    #1;
    chk("reset_armed", int'(armed8), 0);
    chk("reset_result", int'(result8), 0);

    // single qualified vote, then a re-press without arming must not count
    a0 = acks8;
    arm_pulse();
    press(4'b0001, 15);
    press('0, 4);
    #1;
    chk("t2_acks", acks8 - a0, 1);
    chk("t2_idx", last_idx8, 0);
    press(4'b0001, 15);
    press('0, 4);
    #1;
    chk("t2_no_rearm", acks8 - a0, 1);

    // short press on button0 aborted, then button1 held long enough
    arm_pulse();
    press(4'b0001, 5);
    press('0, 3);
    press(4'b0010, 14);
    press('0, 4);
    #1;
    chk("t3_acks", acks8 - a0, 2);
    chk("t3_idx", last_idx8, 1);

    // two buttons together never qualify
    arm_pulse();
    press(4'b0101, 20);
    #1;
    chk("t4_armed", int'(armed8), 1);
    chk("t4_acks", acks8 - a0, 2);
    press('0, 2);
    mode = 1'b1; tick(2); mode = 1'b0; tick(1);

    cast_vote(0);
    cast_vote(0);

    // readback of tallies {3,1,0,0}
    mode = 1'b1;
    press(4'b0001, 4); #1 chk("t5_res0", int'(result8), 3);
    press(4'b0100, 4); #1 chk("t5_res2", int'(result8), 0);
    press(4'b0010, 4); #1 chk("t5_res1", int'(result8), 1);
    press(4'b0000, 4); #1 chk("t5_hold", int'(result8), 1);
`ifdef EVM_WINNER_EN
    chk("t5_winner", int'(winner8), 0);
    chk("t5_tie", int'(tie8), 0);
`endif
    mode = 1'b0;
    tick(2);
    #1 chk("t5_clear", int'(result8), 0);

    // saturation on the 2-bit instance
    a2 = acks2;
    for (int k = 0; k < 4; k++) cast_vote(3);
    #1;
    chk("t6_acks2", acks2 - a2, 4);
    chk("t6_ovf2", int'(overflow2), 1);
    chk("t6_ovf8", int'(overflow8), 0);
    mode = 1'b1;
    press(4'b1000, 4);
    #1;
    chk("t6_res2", int'(result2), 3);
    chk("t6_res8", int'(result8), 4);

    // reset while showing a tally, then reset mid-hold
    do_reset();
    mode = 1'b0;
    arm_pulse();
    press(4'b0001, 6);
    #1 chk("t1_armed_before", int'(armed8), 1);
    do_reset();
    press(4'b0001, 12);
    press('0, 4);
    mode = 1'b1;
    press(4'b0001, 4);
    #1 chk("t1_no_partial", int'(result8), 0);
    mode = 1'b0;
    press('0, 2);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        arm_pulse();
      end else if (r < 80) begin
        if ($urandom_range(0, 4) == 0) msk = 4'($urandom_range(0, 15));
        else msk = 4'b0001 << $urandom_range(0, 3);
        press(msk, $urandom_range(1, 16));
      end else if (r < 92) begin
        press('0, $urandom_range(1, 4));
      end else if (r < 98) begin
        if (mode || ($urandom_range(0, 2) == 0)) mode = ~mode;
        tick(1);
      end else begin
        do_reset();
      end
    end
    press('0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
